seqdet_scan_ctrl: RTL and testbench
===================================

Name: seqdet_scan_ctrl

Overview:
Controller that feeds parallel words, MSB-first, one bit per clock into a programmable serial pattern detector. It counts pattern hits and signals end-of-word with a pulse. It sits between a word-wide producer (valid/ready) and the status/interrupt logic. It generalises the fixed "10010" detector into a configurable, software-visible scan engine. History carries across words, so patterns that span word boundaries are detected.

Parameters:
DATA_W, 8, width of input word; bits consumed per accepted word
PAT_MAX, 8, maximum pattern length in bits
CNT_W, 8, width of saturating hit counter

Ports:
Clk  input  1  clock, posedge active
rst_n  input  1  reset, asynchronous, active-low
clr  input  1  synchronous clear: abort word, flush history, zero counter
cfg_we  input  1  config write strobe
cfg_pattern  input  PAT_MAX  pattern, LSB = most recent bit
cfg_len  input  4  pattern length, legal 1..PAT_MAX
cfg_err  output  1  1-cycle pulse: config write rejected
in_valid  input  1  word available
in_data  input  DATA_W  word to scan
in_ready  output  1  controller can accept a word
bit_out  output  1  bit being shifted this cycle (0 when idle)
busy  output  1  word in flight
hit  output  1  1-cycle pulse: pattern matched on the last shifted bit
done  output  1  1-cycle pulse: last bit of word shifted
hit_cnt  output  CNT_W  saturating hit count since reset/clr

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE; pattern=5'b10010 (zero-extended); len=5; history=0; fill=0.
  - hit=0, done=0, cfg_err=0, hit_cnt=0, busy=0, bit_out=0.
  - in_ready=1 once rst_n is high, because in_ready = (state==IDLE) & ~clr.
- FSM states: IDLE, SHIFT.
  - IDLE -> SHIFT on in_valid & in_ready. At that edge in_data loads into shreg and bitcnt=DATA_W-1.
  - SHIFT, every cycle:
    - bit_out = shreg[DATA_W-1].
    - At the edge: hist <= {hist[PAT_MAX-2:0], bit_out}; shreg <<= 1; fill <= min(fill+1, PAT_MAX); bitcnt--.
  - SHIFT -> IDLE at the edge where bitcnt==0. done is registered high for the following cycle, and in_ready is high in that same cycle.
  - Back-to-back throughput: one word per DATA_W+1 cycles.
- Match rule: hit is registered at the shift edge and is 1 iff both hold:
  - the low len bits of the new history equal the low len bits of pattern, and
  - new fill >= len.
  - Overlapping matches count (10010010 with 10010 gives 2 hits).
  - Latency: hit for bit k of a word appears in cycle k+1 after the accept edge (k=1..DATA_W).
- hit_cnt increments at the same edge hit is set. It saturates at 2^CNT_W-1 and never wraps.
- History and fill persist across words and across IDLE gaps.
- Config:
  - cfg_we is honoured only in IDLE with cfg_len in 1..PAT_MAX. A successful write updates pattern/len and clears history and fill. hit_cnt is not cleared.
  - cfg_we in SHIFT, or with an illegal len: config unchanged, cfg_err pulses the next cycle.
  - cfg_we and an accept in the same IDLE cycle: the config applies first, then the word is scanned with the new config.
- clr (any state, highest priority):
  - Next edge: state=IDLE, hist=0, fill=0, hit_cnt=0, hit=0, done=0. The in-flight word is dropped with no done pulse.
  - in_ready is forced 0 while clr is high, so no accept happens that cycle.
  - clr also overrides cfg_we: the write is ignored and no cfg_err.
- Reset mid-word: everything returns to reset values immediately; the partial word is lost.
- in_data is sampled only at the accept edge. Changes during SHIFT have no effect.

Decomposition:
- Package seqdet_pkg holds:
  - state enum (IDLE, SHIFT)
  - default pattern constant 10010
  - default length constant 5
  - legal-length check function
- One natural sub-module: seqdet_match_core. It holds hist, fill and the compare logic, and outputs hit. The controller keeps the FSM, shreg, bitcnt, config registers and counter.

Test Plan:
1. Defaults, word 8'b1001_0010 -> hit at bits 5 and 8, hit_cnt=2, done in cycle 9 after accept, in_ready=1 in cycle 9.
2. Cross-word: 8'h01 then 8'h20 -> no hit in word 1; hit at bit 4 of word 2; hit_cnt=1.
3. Config pattern=3'b101, len=3, then word 8'hAA -> hits at bits 3, 5, 7; hit_cnt=3; history flushed so no early hit.
4. Errors:
   - cfg_len=0 in IDLE -> cfg_err pulse, pattern stays 10010.
   - cfg_we during SHIFT -> cfg_err, scan unaffected.
5. Accept 8'h92, clr after 3 bits -> no done, hit_cnt=0, in_ready=1 the cycle after clr drops; next word 8'h92 gives 2 hits (fill restarts).
6. CNT_W=2, stream 8'h92 x3 (hits span words) -> hit_cnt saturates at 3 and does not wrap.
   - Separately, rst_n low mid-word -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/seqdet_pkg.sv
// seqdet_pkg: shared types and constants for the serial pattern scan engine.
package seqdet_pkg;

   typedef enum logic {IDLE, SHIFT} state_e;

   localparam logic [4:0] DEF_PATTERN = 5'b10010;
   localparam logic [3:0] DEF_LEN     = 4'd5;

   function automatic logic len_ok(input logic [3:0] len, input int pat_max);
      return (len != 4'd0) && (int'(len) <= pat_max);
   endfunction

endpackage

// File: rtl/seqdet_match_core.sv
// seqdet_match_core: bit history, fill level and masked pattern compare.
// hit_d is the combinational match for the bit shifted this cycle; hit is its registered pulse.
module seqdet_match_core
   import seqdet_pkg::*;
#(
   parameter int PAT_MAX = 8
) (
   input  logic               Clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               shift_en,
   input  logic               bit_in,
   input  logic [PAT_MAX-1:0] pattern,
   input  logic [3:0]         len,
   output logic               hit_d,
   output logic               hit
);

   localparam logic [3:0] FILL_MAX = 4'(PAT_MAX);

   logic [PAT_MAX-1:0] hist_q, hist_d, mask;
   logic [3:0]         fill_q, fill_d;
   logic               hit_q;

   assign hist_d = {hist_q[PAT_MAX-2:0], bit_in};
   assign fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + 4'd1;
   // Only the newest len history bits take part in the compare.
   assign mask   = ~({PAT_MAX{1'b1}} << len);
   assign hit_d  = shift_en & ~flush & (((hist_d ^ pattern) & mask) == '0) & (fill_d >= len);
   assign hit    = hit_q;

   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_q <= '0;
         fill_q <= '0;
         hit_q  <= 1'b0;
      end else if (flush) begin
         hist_q <= '0;
         fill_q <= '0;
         hit_q  <= 1'b0;
      end else begin
         hit_q <= hit_d;
         if (shift_en) begin
            hist_q <= hist_d;
            fill_q <= fill_d;
         end
      end
   end

endmodule

// File: rtl/seqdet_scan_ctrl.sv
// seqdet_scan_ctrl: accepts words, shifts them MSB-first into the match core,
// and keeps the pattern config, end-of-word pulse and saturating hit counter.
module seqdet_scan_ctrl
   import seqdet_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int PAT_MAX = 8,
   parameter int CNT_W   = 8
) (
   input  logic               Clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               cfg_we,
   input  logic [PAT_MAX-1:0] cfg_pattern,
   input  logic [3:0]         cfg_len,
   output logic               cfg_err,
   input  logic               in_valid,
   input  logic [DATA_W-1:0]  in_data,
   output logic               in_ready,
   output logic               bit_out,
   output logic               busy,
   output logic               hit,
   output logic               done,
   output logic [CNT_W-1:0]   hit_cnt
);

   localparam int             BW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BW-1:0]  LAST_BIT = BW'(DATA_W - 1);

   state_e             state_q;
   logic [DATA_W-1:0]  shreg_q;
   logic [BW-1:0]      bitcnt_q;
   logic [PAT_MAX-1:0] pat_q;
   logic [3:0]         len_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               done_q, err_q;
   logic               idle, accept, cfg_legal, cfg_ok, hit_d;

   assign idle      = (state_q == IDLE);
   assign in_ready  = idle & ~clr;
   assign accept    = in_valid & in_ready;
   assign cfg_legal = idle & len_ok(cfg_len, PAT_MAX);
   assign cfg_ok    = cfg_we & ~clr & cfg_legal;
   assign busy      = ~idle;
   assign bit_out   = ~idle & shreg_q[DATA_W-1];
   assign done      = done_q;
   assign cfg_err   = err_q;
   assign hit_cnt   = cnt_q;

   // A successful config write flushes history so stale bits cannot match the new pattern.
   seqdet_match_core #(.PAT_MAX(PAT_MAX)) u_core (
      .Clk      (Clk),
      .rst_n    (rst_n),
      .flush    (clr | cfg_ok),
      .shift_en (~idle & ~clr),
      .bit_in   (shreg_q[DATA_W-1]),
      .pattern  (pat_q),
      .len      (len_q),
      .hit_d    (hit_d),
      .hit      (hit)
   );

   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         shreg_q  <= '0;
         bitcnt_q <= '0;
         pat_q    <= PAT_MAX'(DEF_PATTERN);
         len_q    <= DEF_LEN;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else if (clr) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         err_q  <= cfg_we & ~cfg_legal;
         done_q <= 1'b0;
         if (cfg_ok) begin
            pat_q <= cfg_pattern;
            len_q <= cfg_len;
         end
         if (hit_d && cnt_q != '1)
            cnt_q <= cnt_q + 1'b1;
         if (accept) begin
            shreg_q  <= in_data;
            bitcnt_q <= LAST_BIT;
            state_q  <= SHIFT;
         end else if (!idle) begin
            shreg_q  <= shreg_q << 1;
            bitcnt_q <= bitcnt_q - 1'b1;
            if (bitcnt_q == '0) begin
               state_q <= IDLE;
               done_q  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_seqdet_scan_ctrl.sv
// tb_seqdet_scan_ctrl: directed scans checked every cycle against a bit-stream model,
// with literal expectations on hit positions, done timing and counts.
module tb_seqdet_scan_ctrl;

   logic       Clk = 0, rst_n = 0, clr = 0, cfg_we = 0, in_valid = 0;
   logic [7:0] cfg_pattern = 0, in_data = 0;
   logic [3:0] cfg_len = 0;
   logic       cfg_err, in_ready, bit_out, busy, hit, done;
   logic       cfg_err2, in_ready2, bit_out2, busy2, hit2, done2;
   logic [7:0] hit_cnt;
   logic [1:0] hit_cnt2;

   always #5 Clk = ~Clk;

   seqdet_scan_ctrl #(.DATA_W(8), .PAT_MAX(8), .CNT_W(8)) dut (
      .Clk(Clk), .rst_n(rst_n), .clr(clr), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_err(cfg_err), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .bit_out(bit_out), .busy(busy), .hit(hit), .done(done),
      .hit_cnt(hit_cnt)
   );

   seqdet_scan_ctrl #(.DATA_W(8), .PAT_MAX(8), .CNT_W(2)) dut2 (
      .Clk(Clk), .rst_n(rst_n), .clr(clr), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_err(cfg_err2), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready2), .bit_out(bit_out2), .busy(busy2), .hit(hit2), .done(done2),
      .hit_cnt(hit_cnt2)
   );

   int checks = 0, failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: the full shifted bit stream (newest last, at most 8 kept) compared against the pattern.
   logic       m_busy = 0, m_hit = 0, m_done = 0, m_err = 0;
   int         m_pos = 0, m_cnt = 0, m_len = 5;
   logic [7:0] m_word = 0, m_pat = 8'b10010;
   bit         m_stream[$];

   function automatic bit m_match();
      if (m_stream.size() < m_len) return 0;
      for (int i = 0; i < m_len; i++)
         if (m_stream[m_stream.size()-1-i] != m_pat[i]) return 0;
      return 1;
   endfunction

   initial forever begin
      @(posedge Clk or negedge rst_n);
      if (!rst_n) begin
         m_busy = 0; m_hit = 0; m_done = 0; m_err = 0; m_cnt = 0;
         m_pat = 8'b10010; m_len = 5; m_stream.delete();
      end else begin
         m_hit = 0; m_done = 0; m_err = 0;
         if (clr) begin
            m_busy = 0; m_cnt = 0; m_stream.delete();
         end else begin
            if (cfg_we) begin
               if (!m_busy && cfg_len >= 1 && cfg_len <= 8) begin
                  m_pat = cfg_pattern; m_len = int'(cfg_len); m_stream.delete();
               end else m_err = 1;
            end
            if (m_busy) begin
               m_stream.push_back(m_word[7-m_pos]);
               if (m_stream.size() > 8) void'(m_stream.pop_front());
               if (m_match()) begin
                  m_hit = 1;
                  if (m_cnt < 255) m_cnt++;
               end
               m_pos++;
               if (m_pos == 8) begin m_busy = 0; m_done = 1; end
            end else if (in_valid) begin
               m_busy = 1; m_word = in_data; m_pos = 0;
            end
         end
      end
   end

   initial forever begin
      @(negedge Clk);
      chk("busy", busy, m_busy);
      chk("bit_out", bit_out, m_busy ? m_word[7-m_pos] : 1'b0);
      chk("in_ready", in_ready, !m_busy && !clr);
      chk("hit", hit, m_hit);
      chk("done", done, m_done);
      chk("cfg_err", cfg_err, m_err);
      chk("hit_cnt", hit_cnt, m_cnt);
      chk("busy2", busy2, m_busy);
      chk("bit_out2", bit_out2, m_busy ? m_word[7-m_pos] : 1'b0);
      chk("in_ready2", in_ready2, !m_busy && !clr);
      chk("hit2", hit2, m_hit);
      chk("done2", done2, m_done);
      chk("cfg_err2", cfg_err2, m_err);
      chk("hit_cnt2", hit_cnt2, m_cnt > 3 ? 3 : m_cnt);
   end

   task automatic do_reset();
      @(posedge Clk); #1 rst_n = 0;
      @(posedge Clk); #1 rst_n = 1;
   endtask

   // Cycle c counts from the accept edge; hm/em record hit/cfg_err per cycle, dc the done cycle.
   task automatic send_word(input logic [7:0] d, input int cfg_at, input int clr_at,
                            output logic [15:0] hm, output int dc, output logic [15:0] em);
      hm = 0; em = 0; dc = 0;
      @(posedge Clk); #1 in_valid = 1; in_data = d; cfg_we = (cfg_at == 0);
      @(posedge Clk); #1 in_valid = 0; cfg_we = 0; in_data = ~d;
      for (int c = 1; c <= 10; c++) begin
         cfg_we = (c == cfg_at);
         clr    = (c == clr_at);
         @(negedge Clk);
         hm[c] = hit;
         em[c] = cfg_err;
         if (done && dc == 0) dc = c;
         @(posedge Clk); #1;
      end
      cfg_we = 0; clr = 0;
   endtask

   task automatic cfg_write(input logic [7:0] p, input logic [3:0] l, output logic err);
      @(posedge Clk); #1 cfg_pattern = p; cfg_len = l; cfg_we = 1;
      @(posedge Clk); #1 cfg_we = 0;
      @(negedge Clk); err = cfg_err;
   endtask

   logic [15:0] hm, em;
   int          dc;
   logic        err;

   initial begin
      repeat (2) @(posedge Clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_cnt", hit_cnt, 0);
      rst_n = 1;
      @(negedge Clk);
      chk("rst_ready", in_ready, 1);

      send_word(8'h92, -1, -1, hm, dc, em);
      chk("t1_hits", hm, 16'h0240);
      chk("t1_done", dc, 9);
      chk("t1_cnt", hit_cnt, 2);

      do_reset();
      send_word(8'h01, -1, -1, hm, dc, em);
      chk("t2_hits_w1", hm, 16'h0000);
      send_word(8'h20, -1, -1, hm, dc, em);
      chk("t2_hits_w2", hm, 16'h0020);
      chk("t2_cnt", hit_cnt, 1);

      do_reset();
      send_word(8'h02, -1, -1, hm, dc, em);
      chk("t3_hits_pre", hm, 16'h0000);
      cfg_pattern = 8'b101; cfg_len = 4'd3;
      send_word(8'hAA, 0, -1, hm, dc, em);
      chk("t3_hits", hm, 16'h0150);
      chk("t3_cnt", hit_cnt, 3);
      chk("t3_err", em, 16'h0000);

      do_reset();
      cfg_write(8'b101, 4'd0, err);
      chk("t4_err_len0", err, 1);
      cfg_write(8'b101, 4'd9, err);
      chk("t4_err_len9", err, 1);
      send_word(8'h92, 3, -1, hm, dc, em);
      chk("t4_hits", hm, 16'h0240);
      chk("t4_err_shift", em, 16'h0010);
      chk("t4_done", dc, 9);
      chk("t4_cnt", hit_cnt, 2);

      do_reset();
      send_word(8'h92, -1, 3, hm, dc, em);
      chk("t5_hits_clr", hm, 16'h0000);
      chk("t5_done_clr", dc, 0);
      chk("t5_cnt_clr", hit_cnt, 0);
      send_word(8'h92, -1, -1, hm, dc, em);
      chk("t5_hits", hm, 16'h0240);
      chk("t5_cnt", hit_cnt, 2);
      @(posedge Clk); #1 clr = 1; in_valid = 1; in_data = 8'h92;
      @(negedge Clk);
      chk("t5_ready_clr", in_ready, 0);
      @(posedge Clk); #1 clr = 0; in_valid = 0;
      @(negedge Clk);
      chk("t5_no_accept", busy, 0);

      do_reset();
      repeat (3) send_word(8'h92, -1, -1, hm, dc, em);
      chk("t6_cnt8", hit_cnt, 6);
      chk("t6_cnt2_sat", hit_cnt2, 3);
      @(posedge Clk); #1 in_valid = 1; in_data = 8'h92;
      @(posedge Clk); #1 in_valid = 0;
      repeat (3) @(posedge Clk);
      #1 chk("t6_busy_pre", busy, 1);
      #1 rst_n = 0;
      #1;
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_cnt", hit_cnt, 0);
      chk("t6_rst_cnt2", hit_cnt2, 0);
      chk("t6_rst_bit", bit_out, 0);
      chk("t6_rst_done", done, 0);
      chk("t6_rst_hit", hit, 0);
      @(posedge Clk); #1 rst_n = 1;
      repeat (3) @(posedge Clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
